// File: rtl/dadda_sched_pkg.sv
// Shared constants, output-stage state type and helpers for the dadda16 round-robin scheduler.
package dadda_sched_pkg;

  localparam int W      = 16;
  localparam int PROD_W = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Smallest r with 2**r >= n, used for index and pointer widths.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < n) ? i + 1 : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/dadda16.sv
// Shared unsigned 16x16 multiplier datapath; purely combinational, full 32-bit product.
module dadda16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  assign p = 32'(a) * 32'(b);

endmodule

// File: rtl/dadda16_rr_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or above ptr, with wrap.
module rr_arbiter
  import dadda_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = clog2_f(N);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] ptr_nxt_s;
  logic [N-1:0]     gnt_s;
  int               off_s;
  int               best_off_s;
  int               best_idx_s;

  // Distance of each request from ptr going upward; keep the closest one.
  always_comb begin
    off_s      = 0;
    best_off_s = N;
    best_idx_s = 0;
    for (int i = 0; i < N; i++) begin
      off_s      = (i + N - int'(ptr_r)) % N;
      best_idx_s = (req[i] && (off_s < best_off_s)) ? i : best_idx_s;
      best_off_s = (req[i] && (off_s < best_off_s)) ? off_s : best_off_s;
    end
  end

  // Grant and pointer advance only when enabled and something is requesting.
  always_comb begin
    gnt_s     = '0;
    ptr_nxt_s = ptr_r;
    if (en && (best_off_s < N)) begin
      gnt_s     = {{(N-1){1'b0}}, 1'b1} << best_idx_s;
      ptr_nxt_s = PTR_W'((best_idx_s + 1) % N);
    end else begin
      gnt_s     = '0;
      ptr_nxt_s = ptr_r;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/dadda16_rr_sched.sv
// Round-robin scheduler sharing one dadda16 multiplier among N valid/ready requesters.
// Define MULT_PIPE_EN to add an operand register stage ahead of the multiplier (2-cycle latency).
module dadda16_rr_sched
  import dadda_sched_pkg::*;
#(
  parameter int  N     = 4,
  parameter int  W     = dadda_sched_pkg::W,
  parameter int  CNT_W = 16,
  localparam int ID_W  = clog2_f(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*W-1:0]   res_data,
  output logic [ID_W-1:0]  res_id,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  logic [N-1:0]      gnt_s;
  logic              any_gnt_s;
  logic              grant_en_s;
  logic              s2_free_s;
  logic              mul_load_s;
  logic              drain_s;
  logic [W-1:0]      mux_a_s;
  logic [W-1:0]      mux_b_s;
  logic [ID_W-1:0]   mux_id_s;
  logic [W-1:0]      mul_a_s;
  logic [W-1:0]      mul_b_s;
  logic [ID_W-1:0]   mul_id_s;
  logic [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0] res_data_r;
  logic [ID_W-1:0]   res_id_r;
  logic [CNT_W-1:0]  done_cnt_r;
  out_state_e        state_r;
  out_state_e        state_nxt_s;

  rr_arbiter #(.N(N)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (grant_en_s && !rst),
    .gnt (gnt_s)
  );

  // One-hot operand mux steered by the grant.
  always_comb begin
    mux_a_s  = '0;
    mux_b_s  = '0;
    mux_id_s = '0;
    for (int i = 0; i < N; i++) begin
      mux_a_s  = mux_a_s  | (req_a[i*W +: W] & {W{gnt_s[i]}});
      mux_b_s  = mux_b_s  | (req_b[i*W +: W] & {W{gnt_s[i]}});
      mux_id_s = mux_id_s | (ID_W'(i) & {ID_W{gnt_s[i]}});
    end
  end

  assign any_gnt_s = |gnt_s;
  assign s2_free_s = (state_r == ST_EMPTY) || res_ready;
  assign drain_s   = (state_r == ST_FULL) && res_ready;

`ifdef MULT_PIPE_EN
  logic            s1_valid_r;
  logic [W-1:0]    s1_a_r;
  logic [W-1:0]    s1_b_r;
  logic [ID_W-1:0] s1_id_r;

  // Stage 1 moves on whenever the output stage is free, so a grant may refill it in the same cycle.
  assign grant_en_s = !s1_valid_r || s2_free_s;
  assign mul_load_s = s1_valid_r && s2_free_s;
  assign mul_a_s    = s1_a_r;
  assign mul_b_s    = s1_b_r;
  assign mul_id_s   = s1_id_r;
  assign busy       = s1_valid_r || (state_r == ST_FULL);

  // Operand stage: capture on grant, empty when it advances without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_id_r    <= '0;
    end else if (any_gnt_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= mux_a_s;
      s1_b_r     <= mux_b_s;
      s1_id_r    <= mux_id_s;
    end else if (mul_load_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end
`else
  assign grant_en_s = s2_free_s;
  assign mul_load_s = any_gnt_s;
  assign mul_a_s    = mux_a_s;
  assign mul_b_s    = mux_b_s;
  assign mul_id_s   = mux_id_s;
  assign busy       = (state_r == ST_FULL);
`endif

  dadda16 u_mul (
    .a (mul_a_s),
    .b (mul_b_s),
    .p (prod_s)
  );

  // Output stage next state: a load always wins, otherwise a drain empties it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (mul_load_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (mul_load_s) begin
          state_nxt_s = ST_FULL;
        end else if (res_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Output stage state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Product and owner id, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_r <= '0;
      res_id_r   <= '0;
    end else if (mul_load_s) begin
      res_data_r <= prod_s;
      res_id_r   <= mul_id_s;
    end else begin
      res_data_r <= res_data_r;
      res_id_r   <= res_id_r;
    end
  end

  // Completed-transfer counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt_r <= '0;
    end else if (drain_s) begin
      done_cnt_r <= done_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      done_cnt_r <= done_cnt_r;
    end
  end

  assign req_ready = gnt_s;
  assign res_valid = (state_r == ST_FULL);
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;
  assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_dadda16_rr_sched.sv
// Directed bench for dadda16_rr_sched; follows MULT_PIPE_EN for the expected latency.
module tb_dadda16_rr_sched;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int CNT_W = 16;
  localparam int ID_W  = 2;
`ifdef MULT_PIPE_EN
  localparam int LAT   = 2;
`else
  localparam int LAT   = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_ready;
  logic             res_valid;
  logic             res_ready;
  logic [2*W-1:0]   res_data;
  logic [ID_W-1:0]  res_id;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               gnt_cnt [N];
  logic [31:0]      exp_q [$];
  logic [ID_W-1:0]  id_q [$];
  logic [15:0]      exp_done;
  logic [31:0]      t3_exp [4];

  dadda16_rr_sched #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // One scoreboarded cycle: protocol checks, result check, grant capture, then clock.
  task automatic sb_cycle();
    logic [N-1:0] acc;
    #1;
    chk("onehot", 64'($onehot0(req_ready)), 64'd1);
    chk("grant_to_valid", 64'(req_ready & ~req_valid), 64'd0);
    if (res_valid && res_ready) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("sb_data", 64'(res_data), 64'(exp_q[0]));
        chk("sb_id", 64'(res_id), 64'(id_q[0]));
        void'(exp_q.pop_front());
        void'(id_q.pop_front());
      end
      exp_done = exp_done + 16'd1;
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        exp_q.push_back(32'(req_a[i*W +: W]) * 32'(req_b[i*W +: W]));
        id_q.push_back(ID_W'(i));
        gnt_cnt[i]++;
      end
    end
    acc = req_ready;
    step();
    req_valid = req_valid & ~acc;
  endtask

  initial begin
    int g3;
    t3_exp[0] = 32'd3600000000;
    t3_exp[1] = 32'd3070980;
    t3_exp[2] = 32'd1661044;
    t3_exp[3] = 32'd16769025;
    for (int i = 0; i < N; i++) gnt_cnt[i] = 0;

    // Reset with every requester asking.
    rst = 1'b1; req_valid = 4'hF; res_ready = 1'b0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    rst = 1'b0; req_valid = 4'h0;
    step();

    // Single request from requester 0.
    set_op(0, 16'd1500, 16'd198);
    req_valid = 4'b0001; res_ready = 1'b1; #1;
    chk("t2_ready", 64'(req_ready), 64'd1);
    step(); req_valid = 4'b0000;
    repeat (LAT - 1) begin #1; chk("t2_not_yet", 64'(res_valid), 64'd0); step(); end
    #1;
    chk("t2_valid", 64'(res_valid), 64'd1);
    chk("t2_data", 64'(res_data), 64'd297000);
    chk("t2_id", 64'(res_id), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    step(); #1;
    chk("t2_drained", 64'(res_valid), 64'd0);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);

    // Reset returns ptr to 0, then all four requesters at full throughput.
    rst = 1'b1; step(); rst = 1'b0;
    set_op(0, 16'd60000, 16'd60000);
    set_op(1, 16'd5445, 16'd564);
    set_op(2, 16'd154, 16'd10786);
    set_op(3, 16'd4095, 16'd4095);
    req_valid = 4'hF; res_ready = 1'b1;
    for (int u = 0; u < 4 + LAT; u++) begin
      #1;
      if (u < 4) chk("t3_ready", 64'(req_ready), 64'd1 << u);
      else       chk("t3_ready_idle", 64'(req_ready), 64'd0);
      if (u >= LAT) begin
        chk("t3_valid", 64'(res_valid), 64'd1);
        chk("t3_data", 64'(res_data), 64'(t3_exp[u-LAT]));
        chk("t3_id", 64'(res_id), 64'(u - LAT));
      end else begin
        chk("t3_valid_early", 64'(res_valid), 64'd0);
      end
      step();
      if (u < 4) req_valid[u] = 1'b0;
    end
    #1;
    chk("t3_empty", 64'(res_valid), 64'd0);
    chk("t3_done_cnt", 64'(done_cnt), 64'd4);
    chk("t3_busy", 64'(busy), 64'd0);

    // Backpressure with requesters 1..3 pending, ptr at 0.
    set_op(1, 16'd3, 16'd7);
    set_op(2, 16'd100, 16'd200);
    set_op(3, 16'd65535, 16'd65535);
    res_ready = 1'b0; req_valid = 4'b1110; #1;
    chk("t4_first_grant", 64'(req_ready), 64'b0010);
    step(); req_valid[1] = 1'b0;
`ifdef MULT_PIPE_EN
    #1;
    chk("t4_second_grant", 64'(req_ready), 64'b0100);
    step(); req_valid[2] = 1'b0;
`endif
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_hold_valid", 64'(res_valid), 64'd1);
      chk("t4_hold_data", 64'(res_data), 64'd21);
      chk("t4_hold_id", 64'(res_id), 64'd1);
      chk("t4_hold_ready", 64'(req_ready), 64'd0);
`ifdef MULT_PIPE_EN
      chk("t4_hold_ptr", 64'(dut.u_arb.ptr_r), 64'd3);
`else
      chk("t4_hold_ptr", 64'(dut.u_arb.ptr_r), 64'd2);
`endif
      step();
    end
    res_ready = 1'b1; #1;
    chk("t4_release_data", 64'(res_data), 64'd21);
`ifdef MULT_PIPE_EN
    chk("t4_release_grant", 64'(req_ready), 64'b1000);
    step(); req_valid[3] = 1'b0; #1;
    chk("t4_next_ready", 64'(req_ready), 64'd0);
`else
    chk("t4_release_grant", 64'(req_ready), 64'b0100);
    step(); req_valid[2] = 1'b0; #1;
    chk("t4_next_ready", 64'(req_ready), 64'b1000);
`endif
    chk("t4_data2", 64'(res_data), 64'd20000);
    chk("t4_id2", 64'(res_id), 64'd2);
    step(); req_valid = 4'b0000; #1;
    chk("t4_data3", 64'(res_data), 64'hFFFE0001);
    chk("t4_id3", 64'(res_id), 64'd3);
    step(); #1;
    chk("t4_empty", 64'(res_valid), 64'd0);
    chk("t4_done_cnt", 64'(done_cnt), 64'd7);
    exp_done = 16'd7;

    // Fairness: req0 always valid, req3 raised once.
    set_op(0, 16'd2, 16'd3);
    set_op(3, 16'd11, 16'd13);
    req_valid = 4'b1001; res_ready = 1'b1;
    g3 = gnt_cnt[3];
    for (int c = 0; c < N; c++) begin
      if (!req_valid[0]) begin
        set_op(0, 16'($urandom), 16'($urandom));
        req_valid[0] = 1'b1;
      end
      sb_cycle();
    end
    chk("fair_req3", 64'(gnt_cnt[3] - g3), 64'd1);

    // Random load with random backpressure.
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 3) != 0)) begin
          set_op(i, 16'($urandom), 16'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      sb_cycle();
    end
    for (int i = 0; i < N; i++) chk("no_starve", 64'(gnt_cnt[i] > 0), 64'd1);
    req_valid = 4'b0000; res_ready = 1'b1;
    for (int c = 0; c < 10; c++) sb_cycle();
    #1;
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_done_cnt", 64'(done_cnt), 64'(exp_done));

    // Counter wrap from all-ones.
    set_op(0, 16'd9, 16'd9);
    res_ready = 1'b0; req_valid = 4'b0001;
    step(); req_valid = 4'b0000;
    repeat (LAT - 1) step();
    #1;
    chk("t6_valid", 64'(res_valid), 64'd1);
    chk("t6_data", 64'(res_data), 64'd81);
    force dut.done_cnt_r = 16'hFFFF;
    #1;
    release dut.done_cnt_r;
    #1;
    chk("t6_preload", 64'(done_cnt), 64'hFFFF);
    res_ready = 1'b1;
    step(); #1;
    chk("t6_wrap", 64'(done_cnt), 64'd0);
    chk("t6_empty", 64'(res_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
